// File: rtl/timer_pkg.sv
// Shared types and constants for the memory-mapped countdown timer.
// Covers FSM states, register offsets, CTRL bit layout and modes.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_MODE = 1;
    localparam int CTRL_IM   = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'd0;
    localparam logic [1:0] MODE_RELOAD  = 2'd1;

endpackage

// File: rtl/timer_dev.sv
// Programmable down-counting timer with one-shot / auto-reload modes.
// Holds the register file, the control FSM and the read mux.
module timer_dev
    import timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        irq
);

    state_t      state;
    logic        en;
    logic [1:0]  mode;
    logic        im;
    logic [31:0] preset;
    logic [31:0] count;
    logic        pend;

    logic        wr_ctrl;
    logic        wr_preset;
    logic        reload;
    logic        set_pend;
    logic        clr_pend;
    logic [31:0] ctrl_word;
    logic        unused;

    // Only the word offset is decoded; the bridge already qualified the hit.
    assign unused    = ^{addr[31:4], addr[1:0], BASE_ADDR};
    assign wr_ctrl   = we && (addr[3:2] == REG_CTRL);
    assign wr_preset = we && (addr[3:2] == REG_PRESET);
    assign reload    = (mode == MODE_RELOAD);

    assign set_pend = (state == ST_CNT) && en && (count <= 32'd1);

    // A mode-0 pending flag survives a write that lands on its INT cycle.
    assign clr_pend = reload ? (state == ST_INT)
                             : ((wr_ctrl || wr_preset) && (state != ST_INT));

    assign irq = im & pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            en     <= 1'b0;
            mode   <= MODE_ONESHOT;
            im     <= 1'b0;
            preset <= '0;
            count  <= '0;
            pend   <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (en) state <= ST_LOAD;
                end
                ST_LOAD: begin
                    count <= preset;
                    state <= ST_CNT;
                end
                ST_CNT: begin
                    if (!en) begin
                        state <= ST_IDLE;
                    end else if (count > 32'd1) begin
                        count <= count - 32'd1;
                    end else begin
                        count <= '0;
                        state <= ST_INT;
                    end
                end
                ST_INT: begin
                    if (reload) begin
                        state <= ST_LOAD;
                    end else begin
                        en    <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (set_pend)      pend <= 1'b1;
            else if (clr_pend) pend <= 1'b0;

            // CPU writes come last so they override the FSM's EN clear.
            if (wr_ctrl) begin
                en   <= wd[CTRL_EN];
                mode <= wd[CTRL_MODE +: 2];
                im   <= wd[CTRL_IM];
            end
            if (wr_preset) preset <= wd;
        end
    end

    always_comb begin
        ctrl_word = '0;
        ctrl_word[CTRL_EN] = en;
        ctrl_word[CTRL_MODE +: 2] = mode;
        ctrl_word[CTRL_IM] = im;
    end

    always_comb begin
        rd = '0;
        unique case (addr[3:2])
            REG_CTRL:   rd = ctrl_word;
            REG_PRESET: rd = preset;
            REG_COUNT:  rd = count;
            default:    rd = '0;
        endcase
    end

endmodule

// File: tb/tb_timer_dev.sv
// Self-checking bench for timer_dev: directed scenarios plus randomized
// trials checked against a closed-form timing model.
module tb_timer_dev;
    import timer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] addr = '0;
    logic        we = 1'b0;
    logic [31:0] wd = '0;
    logic [31:0] rd;
    logic        irq;

    int n_checks = 0;
    int n_fail = 0;

    timer_dev #(.BASE_ADDR(32'h0000_7F00)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .addr  (addr),
        .we    (we),
        .wd    (wd),
        .rd    (rd),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr = a;
        wd = d;
        we = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a,
                          input logic [31:0] exp);
        addr = a;
        #1;
        chk(tag, rd, exp);
    endtask

    task automatic do_reset();
        we = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Expected COUNT and pending flag k edges after the enabling write.
    function automatic void model(input int n, input bit auto_m, input int k,
                                  output logic [31:0] c, output logic p_exp);
        int eff;
        int per;
        int ph;
        eff = (n == 0) ? 1 : n;
        per = eff + 2;
        c = '0;
        p_exp = 1'b0;
        if (k >= 2) begin
            ph = auto_m ? (k - 2) % per : k - 2;
            c = (ph < eff) ? 32'(n - ph) : 32'd0;
            p_exp = auto_m ? (ph == eff) : (k >= eff + 2);
        end
    endfunction

    task automatic trial(input int n, input logic [1:0] mode, input logic im);
        logic [31:0] c_exp;
        logic        p_exp;
        int per;
        bit auto_m;
        auto_m = (mode == 2'd1);
        per = ((n == 0) ? 1 : n) + 2;
        do_reset();
        wr(32'h7F04, 32'(n));
        wr(32'h7F00, {28'd0, im, mode, 1'b1});
        addr = 32'h7F08;
        for (int k = 1; k <= 3 * per; k++) begin
            tick(1);
            model(n, auto_m, k, c_exp, p_exp);
            chk($sformatf("count n=%0d m=%0d k=%0d", n, mode, k), rd, c_exp);
            chk($sformatf("irq n=%0d m=%0d k=%0d", n, mode, k),
                {31'd0, irq}, {31'd0, im & p_exp});
        end
        if (!auto_m)
            rd_chk($sformatf("ctrl_end n=%0d", n), 32'h7F00,
                   {28'd0, im, mode, 1'b0});
    endtask

    initial begin
        // Reset state
        rst_n = 1'b0;
        #2;
        chk("irq_in_reset", {31'd0, irq}, 32'd0);
        rd_chk("rd_ctrl_in_reset", 32'h7F00, 32'd0);
        tick(1);
        rst_n = 1'b1;

        // Reset asserted mid-count
        wr(32'h7F04, 32'd10);
        wr(32'h7F00, 32'h9);
        addr = 32'h7F08;
        tick(7);
        chk("count_before_reset", rd, 32'd5);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("count_reset", rd, 32'd0);
        chk("state_reset", {30'd0, dut.state}, {30'd0, ST_IDLE});
        chk("irq_reset", {31'd0, irq}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rd_chk("rd0_after_reset", 32'h7F00, 32'd0);
        rd_chk("rd4_after_reset", 32'h7F04, 32'd0);
        rd_chk("rd8_after_reset", 32'h7F08, 32'd0);
        tick(20);
        chk("no_irq_after_reset", {31'd0, irq}, 32'd0);

        // One-shot: irq rises 7 edges after the enabling write
        do_reset();
        wr(32'h7F04, 32'd5);
        wr(32'h7F00, 32'h9);
        tick(6);
        chk("oneshot_irq_k6", {31'd0, irq}, 32'd0);
        tick(1);
        chk("oneshot_irq_k7", {31'd0, irq}, 32'd1);
        tick(3);
        chk("oneshot_irq_hold", {31'd0, irq}, 32'd1);
        rd_chk("oneshot_ctrl", 32'h7F00, 32'h8);
        wr(32'h7F00, 32'h0);
        chk("oneshot_irq_cleared", {31'd0, irq}, 32'd0);

        // Directed model trials: one-shot, auto-reload, PRESET=0
        trial(5, 2'd0, 1'b1);
        trial(3, 2'd1, 1'b1);
        trial(0, 2'd0, 1'b1);
        trial(0, 2'd1, 1'b1);
        trial(4, 2'd2, 1'b1);

        // Masked: no irq, pending still set
        do_reset();
        wr(32'h7F04, 32'd4);
        wr(32'h7F00, 32'h1);
        tick(6);
        chk("mask_irq", {31'd0, irq}, 32'd0);
        chk("mask_pend", {31'd0, dut.pend}, 32'd1);
        tick(2);
        chk("mask_pend_hold", {31'd0, dut.pend}, 32'd1);

        // Pause at COUNT=2, then re-enable
        do_reset();
        wr(32'h7F04, 32'd4);
        wr(32'h7F00, 32'h1);
        tick(3);
        wr(32'h7F00, 32'h0);
        addr = 32'h7F08;
        tick(3);
        chk("pause_hold", rd, 32'd2);
        wr(32'h7F08, 32'h1234_5678);
        addr = 32'h7F08;
        #1;
        chk("count_write_ignored", rd, 32'd2);
        wr(32'h7F0C, 32'hFFFF_FFFF);
        rd_chk("addr_c_reads_0", 32'h7F0C, 32'd0);
        wr(32'h7F00, 32'h1);
        addr = 32'h7F08;
        tick(2);
        chk("reenable_reload", rd, 32'd4);

        // PRESET write during CNT leaves COUNT alone
        do_reset();
        wr(32'h7F04, 32'd8);
        wr(32'h7F00, 32'h1);
        tick(2);
        wr(32'h7F04, 32'd3);
        tick(1);
        rd_chk("preset_wr_count", 32'h7F08, 32'd6);
        rd_chk("preset_wr_readback", 32'h7F04, 32'd3);

        // CTRL write on the INT edge in one-shot mode
        do_reset();
        wr(32'h7F04, 32'd2);
        wr(32'h7F00, 32'h9);
        tick(4);
        chk("simul_irq_int", {31'd0, irq}, 32'd1);
        wr(32'h7F00, 32'h9);
        rd_chk("simul_en_kept", 32'h7F00, 32'h9);
        chk("simul_pend_kept", {31'd0, dut.pend}, 32'd1);
        chk("simul_irq_kept", {31'd0, irq}, 32'd1);

        // Randomized trials
        for (int t = 0; t < 10; t++)
            trial(int'($urandom_range(0, 12)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/timer_dev.md
# timer_dev

Memory-mapped programmable timer occupying the 0x7F00–0x7F0F device window behind the system bridge. It consumes the bridge's device-0 write-enable, shared address and write data, and returns its read data to the bridge's device-0 read port. Its interrupt output drives the bridge's single hardware interrupt input. It counts down from a preset value and raises an interrupt in one-shot or auto-reload mode.

## Interface
Parameters:
- `BASE_ADDR`, default 32'h0000_7F00: window base; only `addr[3:2]` is decoded inside the block.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous active-low reset.
- `addr`  input  32  device address from the bridge.
- `we`  input  1  write strobe, already qualified by the bridge's window hit.
- `wd`  input  32  write data.
- `rd`  output  32  read data; combinational from `addr[3:2]`.
- `irq`  output  1  interrupt request to the bridge.

## Operation
Registers (word offsets):
- 0x0 CTRL, read/write. Bit 0 is EN. Bits 2:1 are MODE: 0 = one-shot, 1 = auto-reload, 2 and 3 behave as 0. Bit 3 is IM, the interrupt mask (1 = enabled). Bits 31:4 read 0.
- 0x4 PRESET, read/write, 32 bits.
- 0x8 COUNT, read-only. Writes are ignored.
- 0xC reads 0. Writes are ignored.

State machine, with states IDLE, LOAD, CNT and INT:
- IDLE: if EN=1, go to LOAD.
- LOAD: COUNT <= PRESET, go to CNT.
- CNT:
  - If EN=0, go to IDLE. COUNT holds its value.
  - Else if COUNT > 1, COUNT <= COUNT − 1.
  - Else (COUNT is 0 or 1), COUNT <= 0, PEND <= 1, go to INT.
- INT, MODE 0: EN <= 0, go to IDLE. PEND stays set.
- INT, MODE 1: PEND <= 0, go to LOAD.

Interrupt and register rules:
- `irq` = IM & PEND.
- In mode 0, PEND is cleared by any write to CTRL or PRESET.
- In mode 1, PEND is high for exactly the INT cycle.
- A PRESET write while in CNT does not alter COUNT. It takes effect at the next LOAD.
- Arithmetic is 32-bit unsigned. COUNT never wraps below 0.

Reset values: CTRL=0, PRESET=0, COUNT=0, PEND=0, state IDLE, `irq`=0, `rd`=0 (for offset 0).

Simultaneous events:
- A CPU write to CTRL on the same edge as the INT-state EN clear: the CPU write wins.
- PEND being set (CNT to INT) on the same edge as a clearing write: the set wins.
- Reset asserted mid-count: all state returns to reset values immediately. No interrupt is generated.

## Timing
- A write takes effect on the edge where `we`=1. `rd` reflects it in the following cycle.
- Write EN=1 at edge 0 with PRESET=N (N ≥ 1):
  - LOAD at edge 1.
  - CNT with COUNT=N at edge 2.
  - COUNT=1 at edge N+1.
  - INT and PEND set at edge N+2. `irq` is high from edge N+2 (if IM=1).
- PRESET=0 behaves identically to PRESET=1.
- Mode 1 period is N+2 cycles (INT → LOAD → CNT … → INT). The `irq` pulse is 1 cycle wide.
- Mode 0: IDLE with EN=0 at edge N+3. `irq` stays high until the next CTRL or PRESET write.

## Structure
- Package `timer_pkg` contains:
  - the state enum (IDLE, LOAD, CNT, INT);
  - register offset constants (CTRL=2'd0, PRESET=2'd1, COUNT=2'd2);
  - CTRL bit-position constants (EN, MODE, IM);
  - mode constants.
- No sub-module. A single module holds the register file, the FSM and the read mux.

## Test plan
- Reset check: assert `rst_n`=0 mid-count with COUNT=5 → COUNT=0, state IDLE, `irq`=0; after release, `rd` at 0x0/0x4/0x8 reads 0.
- One-shot: PRESET=5, then CTRL=0x9 (EN, mode 0, IM) → `irq` rises 7 cycles after the CTRL write edge and stays high; CTRL reads 0x8. A CTRL write of 0 drops `irq` the next cycle.
- Auto-reload: PRESET=3, CTRL=0xB → `irq` is a 1-cycle pulse every 5 cycles. COUNT sequence is 3,2,1,0 repeating.
- Masking and pause:
  - CTRL=0x1, PRESET=4 → no `irq`, but PEND is internally set.
  - Clearing EN mid-count at COUNT=2 → COUNT holds 2.
  - Re-enabling → reloads 4.
- Boundaries:
  - PRESET=0 with mode 0 → `irq` 3 cycles after enable.
  - A write to 0x8 (COUNT) is ignored.
  - Address 0xC reads 0.
  - A PRESET write during CNT leaves the current COUNT unchanged.
- Simultaneous: a CTRL write (0x9) on the INT edge in mode 0 → EN remains 1 and PEND remains set.
